// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encodings and field size.
package imem_loader_pkg;

   localparam int LDR_HDR_BYTES = 4;

   typedef enum logic [2:0] {
      LDR_IDLE,
      LDR_LEN,
      LDR_DATA,
      LDR_WRITE,
      LDR_CSUM,
      LDR_DONE,
      LDR_ERR
   } ldr_state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word assembler shared by the length, data and checksum fields.
// The completed word is presented combinationally alongside the pulse on the accepting cycle.
module imem_byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        shift,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [23:0] shreg;
   logic [1:0]  count;

   // Bytes enter from the top so byte k ends up in bits [8k+7:8k] of the finished word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg <= '0;
         count <= '0;
      end else if (clear) begin
         shreg <= '0;
         count <= '0;
      end else if (shift) begin
         shreg <= {byte_data, shreg[23:8]};
         count <= count + 2'd1;
      end
   end

   assign word       = {byte_data, shreg};
   assign word_valid = shift && (count == 2'(LDR_HDR_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Writer side of the instruction memory: turns a byte-stream program image into IMEM word writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word after the data.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          ADDR_W    = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        cpu_hold
);

   localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam ldr_state_t AFTER_DATA = LDR_CSUM;
`else
   localparam ldr_state_t AFTER_DATA = LDR_DONE;
`endif

   ldr_state_t      state;
   ldr_state_t      next_state;
   logic [31:0]     n_words;
   logic [ADDR_W:0] idx;
   logic            done_flag;
   logic            err_flag;
   logic            accept;
   logic            field_valid;
   logic [31:0]     field_word;
   logic            last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0]     csum;
`endif

   assign accept    = byte_valid & byte_ready;
   assign last_word = (33'(idx) == ({1'b0, n_words} - 33'd1));

   imem_byte_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (state == LDR_IDLE),
      .shift      (accept),
      .byte_data  (byte_data),
      .word       (field_word),
      .word_valid (field_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LDR_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      byte_ready = 1'b0;
      mem_we     = 1'b0;
      busy       = 1'b1;
      case (state)
         LDR_IDLE: begin
            busy = 1'b0;
            if (start) begin
               next_state = LDR_LEN;
            end
         end
         LDR_LEN: begin
            byte_ready = 1'b1;
            if (field_valid) begin
               if (field_word == 32'd0) begin
                  next_state = AFTER_DATA;
               end else if ({1'b0, field_word} > CAPACITY) begin
                  next_state = LDR_ERR;
               end else begin
                  next_state = LDR_DATA;
               end
            end
         end
         LDR_DATA: begin
            byte_ready = 1'b1;
            if (field_valid) begin
               next_state = LDR_WRITE;
            end
         end
         LDR_WRITE: begin
            mem_we     = 1'b1;
            next_state = last_word ? AFTER_DATA : LDR_DATA;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         LDR_CSUM: begin
            byte_ready = 1'b1;
            if (field_valid) begin
               next_state = (field_word == csum) ? LDR_DONE : LDR_ERR;
            end
         end
`endif
         LDR_DONE, LDR_ERR: begin
            busy       = 1'b0;
            next_state = LDR_IDLE;
         end
         default: begin
            busy       = 1'b0;
            next_state = LDR_IDLE;
         end
      endcase
   end

   // Status flags are raised on entry to DONE/ERR so they are visible while busy drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_words   <= '0;
         idx       <= '0;
         done_flag <= 1'b0;
         err_flag  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         if (state == LDR_IDLE && start) begin
            idx       <= '0;
            done_flag <= 1'b0;
            err_flag  <= 1'b0;
         end
         if (state == LDR_LEN && field_valid) begin
            n_words <= field_word;
         end
         if (state == LDR_DATA && field_valid) begin
            mem_wdata <= field_word;
            mem_addr  <= BASE_ADDR + (32'(idx) << 2);
         end
         if (state == LDR_WRITE) begin
            idx <= idx + (ADDR_W + 1)'(1);
         end
         if (state != LDR_DONE && next_state == LDR_DONE) begin
            done_flag <= 1'b1;
         end
         if (state != LDR_ERR && next_state == LDR_ERR) begin
            err_flag <= 1'b1;
         end
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum <= '0;
      end else if (state == LDR_IDLE && start) begin
         csum <= '0;
      end else if (state == LDR_WRITE) begin
         csum <= csum ^ mem_wdata;
      end
   end
`endif

   assign done     = done_flag;
   assign err      = err_flag;
   assign cpu_hold = busy;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random images and byte gaps checked against a queue-based model.
// Honors IMEM_LOADER_CHECKSUM_EN by appending the expected checksum word to each image.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic        cpu_hold;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] img[$];
   logic [31:0] expAddr[$];
   logic [31:0] expData[$];
   time         expWeTime[$];

   imem_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .cpu_hold   (cpu_hold)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Every write strobe must match the next expected (address, word) pair and arrive one cycle after its last byte.
   always @(negedge clk) begin
      if (rst_n && mem_we) begin
         checkOutput("readyInWrite", byte_ready, 1'b0);
         if (expAddr.size() == 0) begin
            checkOutput("unexpectedWrite", 1'b1, 1'b0);
         end else begin
            checkOutput("writeAddr", mem_addr, expAddr.pop_front());
            checkOutput("writeData", mem_wdata, expData.pop_front());
         end
         if (expWeTime.size() == 0) begin
            checkOutput("weLatencyMissing", 1'b1, 1'b0);
         end else begin
            checkOutput("weLatency", $time, expWeTime.pop_front());
         end
      end
   end

   task automatic sendByte(input logic [7:0] b, input int gapMax, input bit wordEnd);
      int guard;
      repeat ($urandom_range(gapMax, 0)) @(negedge clk);
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      guard      = 0;
      while (!byte_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!byte_ready) begin
         checkOutput("readyTimeout", 1'b0, 1'b1);
         byte_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (wordEnd) expWeTime.push_back($time + 5);
      #1 byte_valid = 1'b0;
   endtask

   task automatic sendWord(input logic [31:0] w, input int gapMax, input bit isData);
      for (int k = 0; k < 4; k++) begin
         sendByte(w[8*k +: 8], gapMax, isData && (k == 3));
      end
   endtask

   task automatic pulseStart();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] nField, input int gapMax, input bit badCsum,
                                input bit startMid, input string tag);
      bit          lenOk;
      bit          expectErr;
      logic [31:0] csum;
      int          waitCnt;
      lenOk     = ({1'b0, nField} <= 33'h0_0001_0000);
      expectErr = !lenOk;
      csum      = 32'h0;
      expAddr.delete();
      expData.delete();
      expWeTime.delete();
      if (lenOk) begin
         foreach (img[i]) begin
            expAddr.push_back(32'(i) * 4);
            expData.push_back(img[i]);
            csum ^= img[i];
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (lenOk && badCsum) expectErr = 1'b1;
`endif
      pulseStart();
      checkOutput({tag, "_startStatus"}, {busy, cpu_hold, done, err}, 4'b1100);
      sendWord(nField, gapMax, 1'b0);
      if (lenOk) begin
         if (startMid && img.size() > 0) pulseStart();
         foreach (img[i]) sendWord(img[i], gapMax, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
         sendWord(csum + 32'(badCsum), gapMax, 1'b0);
`endif
      end
      waitCnt = 0;
      while (busy && waitCnt < 20) begin
         @(negedge clk);
         waitCnt++;
      end
      checkOutput({tag, "_finishCycles"}, (waitCnt <= 2), 1'b1);
      @(negedge clk);
      checkOutput({tag, "_endStatus"}, {busy, cpu_hold, done, err}, {2'b00, !expectErr, expectErr});
      checkOutput({tag, "_writesLeft"}, expAddr.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      checkOutput("resetOutputs", {byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err, cpu_hold}, '0);
      rst_n = 1'b1;

      img = {32'h0000_0013, 32'h0010_0093};
      applyStimulus(32'd2, 0, 1'b0, 1'b0, "t1");

      img.delete();
      applyStimulus(32'd0, 0, 1'b0, 1'b0, "t2");

      img = {32'h0000_0013, 32'h0010_0093};
      applyStimulus(32'd2, 3, 1'b0, 1'b1, "t3");

      img.delete();
      applyStimulus(32'h0001_0001, 0, 1'b0, 1'b0, "t4");
      applyStimulus(32'hFFFF_FFFF, 1, 1'b0, 1'b0, "t4b");

`ifdef IMEM_LOADER_CHECKSUM_EN
      img = {32'h1111_1111, 32'h2222_2222};
      applyStimulus(32'd2, 0, 1'b0, 1'b0, "t5good");
      applyStimulus(32'd2, 0, 1'b1, 1'b0, "t5bad");
`endif

      img = {32'h0000_0013, 32'h0010_0093};
      expAddr.delete();
      expData.delete();
      expWeTime.delete();
      pulseStart();
      sendWord(32'd2, 0, 1'b0);
      sendByte(8'h13, 0, 1'b0);
      sendByte(8'h00, 0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("t6_resetOutputs", {byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err, cpu_hold}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(32'd2, 1, 1'b0, 1'b0, "t6");

      repeat (6) begin
         n = $urandom_range(8, 1);
         img.delete();
         for (int i = 0; i < n; i++) img.push_back($urandom);
         applyStimulus(32'(n), $urandom_range(3, 0), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
